// File: rtl/player_controller_pkg.sv
// Shared constants for the player controller: screen geometry, sprite and
// projectile sizes, motion steps and the projectile state encoding.
package player_controller_pkg;

    localparam int DISPLAY_H       = 640;
    localparam int PLAYER_WIDTH    = 13;
    localparam int PLAYER_Y_POS    = 440;
    localparam int PLAYER_STEP     = 2;
    localparam int SHOT_HEIGHT     = 4;
    localparam int SHOT_STEP       = 4;

    // Rightmost legal sprite position and the centred start position (313).
    localparam int PLAYER_X_MAX    = DISPLAY_H - PLAYER_WIDTH;
    localparam int PLAYER_X_RESET  = PLAYER_X_MAX / 2;

    // Projectile spawns centred on the sprite, just above it.
    localparam int SHOT_X_OFFSET   = PLAYER_WIDTH / 2;
    localparam int SHOT_Y_START    = PLAYER_Y_POS - SHOT_HEIGHT;

    typedef enum logic {
        SHOT_IDLE   = 1'b0,
        SHOT_FLYING = 1'b1
    } shot_state_t;

endpackage

// File: rtl/player_controller_button_debouncer.sv
// Button debouncer: two-flop synchroniser followed by a stability counter.
// The output only changes after the synchronised input has differed from it
// for DEBOUNCE_CYCLES consecutive clocks; any bounce back restarts the count.
module player_controller_button_debouncer
    import player_controller_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_db
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q;

    // Bring the asynchronous button into the clk domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], btn_raw};
        end
    end

    // Accept the new level only once it has been stable long enough.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            btn_db <= 1'b0;
        end else if (sync_q[1] == btn_db) begin
            cnt_q  <= '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_q  <= '0;
            btn_db <= sync_q[1];
        end else begin
            cnt_q  <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/player_controller.sv
// Player controller: debounces the board buttons and, once per frame_tick,
// moves the player sprite and advances the projectile drawn by the renderer.
// Outputs only change on frame_tick / shot_hit / rst edges, so they are
// stable while the renderer samples them.
// Build option: define PLAYER_WRAP_EN to make the sprite wrap around the
// screen edges instead of clamping at them.
module player_controller
    import player_controller_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_fire,
    input  logic       frame_tick,
    input  logic       shot_hit,
    output logic [9:0] player_x,
    output logic [9:0] player_y,
    output logic       shot_active,
    output logic [9:0] shot_x,
    output logic [9:0] shot_y
);

    localparam logic [10:0] X_MAX_W  = 11'(PLAYER_X_MAX);
    localparam logic [10:0] X_STEP_W = 11'(PLAYER_STEP);

    logic        left_db;
    logic        right_db;
    logic        fire_db;
    logic        fire_prev;
    logic        fire_rise;
    logic        fire_pending;

    shot_state_t state_q;
    shot_state_t state_d;
    logic [9:0]  shot_x_d;
    logic [9:0]  shot_y_d;

    // One step of horizontal motion. Work in 11 bits so the left edge test
    // never underflows and the right edge test never overflows.
    function automatic logic [9:0] next_player_x(input logic [9:0] x,
                                                 input logic       left,
                                                 input logic       right);
        logic [10:0] x_w;
        logic [9:0]  nx;
        x_w = {1'b0, x};
        nx  = x;
        if (left && !right) begin
            if (x_w < X_STEP_W) begin
`ifdef PLAYER_WRAP_EN
                nx = X_MAX_W[9:0];
`else
                nx = 10'd0;
`endif
            end else begin
                nx = 10'(x_w - X_STEP_W);
            end
        end else if (right && !left) begin
            if ((x_w + X_STEP_W) > X_MAX_W) begin
`ifdef PLAYER_WRAP_EN
                nx = 10'd0;
`else
                nx = X_MAX_W[9:0];
`endif
            end else begin
                nx = 10'(x_w + X_STEP_W);
            end
        end
        return nx;
    endfunction

    player_controller_button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db_left (
        .clk    (clk),
        .rst    (rst),
        .btn_raw(btn_left),
        .btn_db (left_db)
    );

    player_controller_button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db_right (
        .clk    (clk),
        .rst    (rst),
        .btn_raw(btn_right),
        .btn_db (right_db)
    );

    player_controller_button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db_fire (
        .clk    (clk),
        .rst    (rst),
        .btn_raw(btn_fire),
        .btn_db (fire_db)
    );

    assign fire_rise   = fire_db && !fire_prev;
    assign player_y    = 10'(PLAYER_Y_POS);
    assign shot_active = (state_q == SHOT_FLYING);

    // Remember the previous debounced fire level for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            fire_prev <= 1'b0;
        end else begin
            fire_prev <= fire_db;
        end
    end

    // A fire press is latched until the next frame; any frame_tick that
    // launches a shot or finds one already flying discards it, so presses
    // are never queued behind an active projectile.
    always_ff @(posedge clk) begin
        if (rst) begin
            fire_pending <= 1'b0;
        end else if (frame_tick && (state_q == SHOT_FLYING || fire_pending)) begin
            fire_pending <= 1'b0;
        end else if (fire_rise) begin
            fire_pending <= 1'b1;
        end
    end

    // Move the sprite once per frame according to the held direction.
    always_ff @(posedge clk) begin
        if (rst) begin
            player_x <= 10'(PLAYER_X_RESET);
        end else if (frame_tick) begin
            player_x <= next_player_x(player_x, left_db, right_db);
        end
    end

    // Projectile state and position register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SHOT_IDLE;
            shot_x  <= 10'd0;
            shot_y  <= 10'd0;
        end else begin
            state_q <= state_d;
            shot_x  <= shot_x_d;
            shot_y  <= shot_y_d;
        end
    end

    // Projectile next state: launch from the pre-move sprite position, rise
    // each frame, vanish off the top edge or on a hit (hit wins over tick).
    always_comb begin
        state_d  = state_q;
        shot_x_d = shot_x;
        shot_y_d = shot_y;
        case (state_q)
            SHOT_IDLE: begin
                if (frame_tick && fire_pending) begin
                    state_d  = SHOT_FLYING;
                    shot_x_d = player_x + 10'(SHOT_X_OFFSET);
                    shot_y_d = 10'(SHOT_Y_START);
                end
            end
            SHOT_FLYING: begin
                if (shot_hit) begin
                    state_d = SHOT_IDLE;
                end else if (frame_tick) begin
                    if (shot_y < 10'(SHOT_STEP)) begin
                        state_d = SHOT_IDLE;
                    end else begin
                        shot_y_d = shot_y - 10'(SHOT_STEP);
                    end
                end
            end
            default: begin
                state_d = SHOT_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_player_controller.sv
// Testbench for player_controller (DEBOUNCE_CYCLES=4). Directed scenarios
// plus randomized button/tick/hit sequences compared against a frame-level
// model of the game rules. Build with PLAYER_WRAP_EN to exercise wrapping.
module tb_player_controller;

    localparam int XMAX   = 627;
    localparam int SETTLE = 10;

    logic       clk;
    logic       rst;
    logic       btn_left;
    logic       btn_right;
    logic       btn_fire;
    logic       frame_tick;
    logic       shot_hit;
    logic [9:0] player_x;
    logic [9:0] player_y;
    logic       shot_active;
    logic [9:0] shot_x;
    logic [9:0] shot_y;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state (frame level, debounced buttons assumed settled).
    int m_px;
    int m_sx;
    int m_sy;
    bit m_sa;
    bit m_pend;
    bit m_fprev;
    bit m_l;
    bit m_r;

    player_controller #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_fire   (btn_fire),
        .frame_tick (frame_tick),
        .shot_hit   (shot_hit),
        .player_x   (player_x),
        .player_y   (player_y),
        .shot_active(shot_active),
        .shot_x     (shot_x),
        .shot_y     (shot_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_px = 313; m_sx = 0; m_sy = 0; m_sa = 0; m_pend = 0; m_fprev = 0;
        m_l = 0; m_r = 0;
    endtask

    // One clock with frame_tick / shot_hit applied, plus the model update.
    task automatic model_event(input bit t, input bit h);
        int old_px;
        old_px = m_px;
        if (t) begin
            if (m_l && !m_r) m_px = old_px - 2;
            else if (m_r && !m_l) m_px = old_px + 2;
`ifdef PLAYER_WRAP_EN
            if (m_px < 0) m_px = XMAX;
            if (m_px > XMAX) m_px = 0;
`else
            if (m_px < 0) m_px = 0;
            if (m_px > XMAX) m_px = XMAX;
`endif
        end
        if (m_sa && h) begin
            m_sa = 0;
            if (t) m_pend = 0;
        end else if (t) begin
            if (m_sa) begin
                m_pend = 0;
                if (m_sy < 4) m_sa = 0;
                else m_sy = m_sy - 4;
            end else if (m_pend) begin
                m_sa = 1; m_sx = old_px + 6; m_sy = 436; m_pend = 0;
            end
        end
    endtask

    // Change the buttons and wait until the debouncers have settled.
    task automatic drive_buttons(input bit l, input bit r, input bit f);
        @(negedge clk);
        btn_left = l; btn_right = r; btn_fire = f;
        repeat (SETTLE) @(negedge clk);
        m_l = l; m_r = r;
        if (f && !m_fprev) m_pend = 1;
        m_fprev = f;
    endtask

    task automatic pulse(input bit t, input bit h);
        @(negedge clk);
        frame_tick = t; shot_hit = h;
        @(negedge clk);
        frame_tick = 1'b0; shot_hit = 1'b0;
        model_event(t, h);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (20) @(negedge clk);
        n_checks++; if (player_x !== 10'd313) begin n_fail++; $display("FAIL reset_px: got %0d expected 313", player_x); end
        n_checks++; if (player_y !== 10'd440) begin n_fail++; $display("FAIL reset_py: got %0d expected 440", player_y); end
        n_checks++; if (shot_active !== 1'b0) begin n_fail++; $display("FAIL reset_active: got %0b expected 0", shot_active); end
        n_checks++; if (shot_x !== 10'd0) begin n_fail++; $display("FAIL reset_sx: got %0d expected 0", shot_x); end
        n_checks++; if (shot_y !== 10'd0) begin n_fail++; $display("FAIL reset_sy: got %0d expected 0", shot_y); end
    endtask

    task automatic test_motion();
        drive_buttons(1'b0, 1'b1, 1'b0);
        repeat (3) pulse(1'b1, 1'b0);
        n_checks++; if (player_x !== 10'd319) begin n_fail++; $display("FAIL motion_right3: got %0d expected 319", player_x); end
        drive_buttons(1'b1, 1'b1, 1'b0);
        pulse(1'b1, 1'b0);
        n_checks++; if (player_x !== 10'd319) begin n_fail++; $display("FAIL motion_both: got %0d expected 319", player_x); end
        pulse(1'b0, 1'b0);
        n_checks++; if (player_x !== 10'd319) begin n_fail++; $display("FAIL motion_notick: got %0d expected 319", player_x); end
        for (int i = 0; i < 30; i++) begin
            drive_buttons(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
            for (int k = 0; k < int'($urandom_range(1, 4)); k++) begin
                pulse(1'b1, 1'b0);
                n_checks++; if (player_x !== 10'(m_px)) begin n_fail++; $display("FAIL motion_rand %0d: got %0d expected %0d", i, player_x, m_px); end
            end
        end
    endtask

    task automatic test_edges();
        int guard;
        drive_buttons(1'b1, 1'b0, 1'b0);
        guard = 0;
        while (m_px != 1 && guard < 400) begin pulse(1'b1, 1'b0); guard++; end
        n_checks++; if (player_x !== 10'd1) begin n_fail++; $display("FAIL edge_px1: got %0d expected 1", player_x); end
        pulse(1'b1, 1'b0);
`ifdef PLAYER_WRAP_EN
        n_checks++; if (player_x !== 10'd627) begin n_fail++; $display("FAIL edge_left: got %0d expected 627", player_x); end
`else
        n_checks++; if (player_x !== 10'd0) begin n_fail++; $display("FAIL edge_left: got %0d expected 0", player_x); end
`endif
        pulse(1'b1, 1'b0);
        n_checks++; if (player_x !== 10'(m_px)) begin n_fail++; $display("FAIL edge_left2: got %0d expected %0d", player_x, m_px); end
        drive_buttons(1'b0, 1'b1, 1'b0);
        guard = 0;
        while (m_px != XMAX && guard < 400) begin pulse(1'b1, 1'b0); guard++; end
        n_checks++; if (player_x !== 10'd627) begin n_fail++; $display("FAIL edge_pxmax: got %0d expected 627", player_x); end
        pulse(1'b1, 1'b0);
`ifdef PLAYER_WRAP_EN
        n_checks++; if (player_x !== 10'd0) begin n_fail++; $display("FAIL edge_right: got %0d expected 0", player_x); end
`else
        n_checks++; if (player_x !== 10'd627) begin n_fail++; $display("FAIL edge_right: got %0d expected 627", player_x); end
`endif
        drive_buttons(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_fire_glitch();
        int px0;
        @(negedge clk);
        btn_fire = 1'b1;
        repeat (2) @(negedge clk);
        btn_fire = 1'b0;
        repeat (SETTLE) @(negedge clk);
        pulse(1'b1, 1'b0);
        n_checks++; if (shot_active !== 1'b0) begin n_fail++; $display("FAIL glitch_noshot: got %0b expected 0", shot_active); end
        drive_buttons(1'b0, 1'b0, 1'b1);
        px0 = m_px;
        pulse(1'b1, 1'b0);
        n_checks++; if (shot_active !== 1'b1) begin n_fail++; $display("FAIL fire_active: got %0b expected 1", shot_active); end
        n_checks++; if (shot_x !== 10'(px0 + 6)) begin n_fail++; $display("FAIL fire_sx: got %0d expected %0d", shot_x, px0 + 6); end
        n_checks++; if (shot_y !== 10'd436) begin n_fail++; $display("FAIL fire_sy: got %0d expected 436", shot_y); end
    endtask

    task automatic test_flight();
        for (int k = 1; k <= 109; k++) begin
            pulse(1'b1, 1'b0);
            n_checks++; if (shot_active !== 1'b1 || shot_y !== 10'(436 - 4 * k)) begin
                n_fail++; $display("FAIL flight_y %0d: got active=%0b y=%0d expected active=1 y=%0d", k, shot_active, shot_y, 436 - 4 * k);
            end
        end
        pulse(1'b1, 1'b0);
        n_checks++; if (shot_active !== 1'b0) begin n_fail++; $display("FAIL flight_off: got %0b expected 0", shot_active); end
        n_checks++; if (shot_y !== 10'd0) begin n_fail++; $display("FAIL flight_hold_y: got %0d expected 0", shot_y); end
        repeat (5) pulse(1'b1, 1'b0);
        n_checks++; if (shot_active !== 1'b0) begin n_fail++; $display("FAIL no_refire: got %0b expected 0", shot_active); end
        drive_buttons(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_hit();
        drive_buttons(1'b0, 1'b0, 1'b1);
        pulse(1'b1, 1'b0);
        repeat (3) pulse(1'b1, 1'b0);
        n_checks++; if (shot_y !== 10'd424) begin n_fail++; $display("FAIL hit_pre_y: got %0d expected 424", shot_y); end
        pulse(1'b1, 1'b1);
        n_checks++; if (shot_active !== 1'b0) begin n_fail++; $display("FAIL hit_kill: got %0b expected 0", shot_active); end
        n_checks++; if (shot_y !== 10'd424) begin n_fail++; $display("FAIL hit_hold_y: got %0d expected 424", shot_y); end
        // hit while idle must not cancel a pending press
        drive_buttons(1'b0, 1'b0, 1'b0);
        drive_buttons(1'b0, 1'b0, 1'b1);
        pulse(1'b0, 1'b1);
        pulse(1'b1, 1'b0);
        n_checks++; if (shot_active !== 1'b1) begin n_fail++; $display("FAIL idle_hit_ignored: got %0b expected 1", shot_active); end
        // press during flight is discarded, not queued
        drive_buttons(1'b0, 1'b0, 1'b0);
        drive_buttons(1'b0, 1'b0, 1'b1);
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        n_checks++; if (shot_active !== 1'b0) begin n_fail++; $display("FAIL hit_only: got %0b expected 0", shot_active); end
        pulse(1'b1, 1'b0);
        n_checks++; if (shot_active !== 1'b0) begin n_fail++; $display("FAIL no_queue: got %0b expected 0", shot_active); end
    endtask

    task automatic test_reset_midflight();
        drive_buttons(1'b0, 1'b1, 1'b0);
        drive_buttons(1'b0, 1'b1, 1'b1);
        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b0);
        n_checks++; if (shot_active !== 1'b1) begin n_fail++; $display("FAIL mid_launch: got %0b expected 1", shot_active); end
        drive_buttons(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        n_checks++; if (shot_active !== 1'b0) begin n_fail++; $display("FAIL mid_rst_active: got %0b expected 0", shot_active); end
        n_checks++; if (shot_x !== 10'd0 || shot_y !== 10'd0) begin n_fail++; $display("FAIL mid_rst_pos: got x=%0d y=%0d expected 0 0", shot_x, shot_y); end
        n_checks++; if (player_x !== 10'd313) begin n_fail++; $display("FAIL mid_rst_px: got %0d expected 313", player_x); end
        repeat (SETTLE) @(negedge clk);
        pulse(1'b1, 1'b0);
        n_checks++; if (shot_active !== 1'b0) begin n_fail++; $display("FAIL mid_rst_nofire: got %0b expected 0", shot_active); end
    endtask

    task automatic test_random();
        bit t;
        bit h;
        for (int i = 0; i < 250; i++) begin
            drive_buttons(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
            for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
                t = ($urandom_range(0, 3) != 0);
                h = ($urandom_range(0, 6) == 0);
                pulse(t, h);
                n_checks++; if (player_x !== 10'(m_px) || shot_active !== m_sa || shot_x !== 10'(m_sx) || shot_y !== 10'(m_sy)) begin
                    n_fail++;
                    $display("FAIL random %0d: got px=%0d act=%0b sx=%0d sy=%0d expected px=%0d act=%0b sx=%0d sy=%0d",
                             i, player_x, shot_active, shot_x, shot_y, m_px, m_sa, m_sx, m_sy);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; btn_left = 1'b0; btn_right = 1'b0; btn_fire = 1'b0;
        frame_tick = 1'b0; shot_hit = 1'b0;
        model_reset();
        test_reset();
        test_motion();
        test_edges();
        test_fire_glitch();
        test_flight();
        test_hit();
        test_reset_midflight();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
